// File: rtl/delay_latency_probe_if.sv
// Delay-path probe bundle: start request, probe/echo words and status.
// The measuring block uses master; the environment uses slave.
interface delay_latency_probe_if #(
    parameter int C_BIT_WIDTH = 20,
    parameter int C_CNT_WIDTH = 16
);
    logic                   start;
    logic [C_BIT_WIDTH-1:0] probe;
    logic [C_BIT_WIDTH-1:0] echo;
    logic                   busy;
    logic                   done;
    logic                   timeout;
    logic                   err;
    logic [C_CNT_WIDTH-1:0] latency;

    modport master (
        input  start, echo,
        output probe, busy, done, timeout, err, latency
    );

    modport slave (
        output start, echo,
        input  probe, busy, done, timeout, err, latency
    );
endinterface

// File: rtl/delay_latency_probe.sv
// Measures round-trip latency of an external delay path by flushing it,
// injecting a marker word and counting cycles until the marker returns.
module delay_latency_probe #(
    parameter int                     C_BIT_WIDTH   = 20,
    parameter int                     C_MAX_LATENCY = 4095,
    parameter int                     C_CNT_WIDTH   = 16,
    parameter logic [C_BIT_WIDTH-1:0] C_MARKER      = 20'hA5A5A
) (
    input logic                   clk,
    input logic                   rst,
    delay_latency_probe_if.master bus
);
    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        MARK,
        WAIT
    } state_t;

    localparam logic [C_CNT_WIDTH-1:0] MAX = C_CNT_WIDTH'(C_MAX_LATENCY);

    state_t                 state;
    logic [C_CNT_WIDTH-1:0] cnt;
    logic [C_BIT_WIDTH-1:0] probe_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   timeout_q;
    logic                   err_q;
    logic [C_CNT_WIDTH-1:0] latency_q;

    logic pulse;
    logic hit;
    logic bad;

    assign pulse = done_q | timeout_q | err_q;
    assign hit   = (bus.echo == C_MARKER);
    assign bad   = (bus.echo != '0) && !hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            probe_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
            latency_q <= '0;
        end else begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
            unique case (state)
                IDLE: begin
                    probe_q <= '0;
                    cnt     <= '0;
                    // the cycle carrying a result pulse never accepts start
                    if (bus.start && !pulse) begin
                        state  <= FLUSH;
                        busy_q <= 1'b1;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (cnt == MAX) begin
                        state   <= MARK;
                        probe_q <= C_MARKER;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                MARK, WAIT: begin
                    probe_q <= '0;
                    if (hit) begin
                        latency_q <= cnt;
                        done_q    <= 1'b1;
                        state     <= IDLE;
                    end else if (bad) begin
                        err_q <= 1'b1;
                        state <= IDLE;
                    end else if (state == WAIT && cnt == MAX) begin
                        timeout_q <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        state <= WAIT;
                        if (cnt != MAX) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.probe   = probe_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.timeout = timeout_q;
    assign bus.err     = err_q;
    assign bus.latency = latency_q;
endmodule

// File: tb/tb_delay_latency_probe.sv
// Directed bench: dut_a (max latency 4095) over loopback and register
// chains, dut_b (max latency 15) for the timeout path.
module tb_delay_latency_probe;
    localparam int W  = 20;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    delay_latency_probe_if #(.C_BIT_WIDTH(W), .C_CNT_WIDTH(CW)) ifa ();
    delay_latency_probe_if #(.C_BIT_WIDTH(W), .C_CNT_WIDTH(CW)) ifb ();

    delay_latency_probe #(.C_MAX_LATENCY(4095)) dut_a (
        .clk(clk),
        .rst(rst),
        .bus(ifa)
    );

    delay_latency_probe #(.C_MAX_LATENCY(15)) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(ifb)
    );

    logic [W-1:0] chain_a [0:2047];
    logic [W-1:0] chain_b [0:7];
    int mode_a = 0;
    int mode_b = 0;
    int tap_a  = 1;
    int tap_b  = 1;

    always @(posedge clk) begin
        chain_a[0] <= ifa.probe;
        for (int i = 1; i < 2048; i++) chain_a[i] <= chain_a[i-1];
        chain_b[0] <= ifb.probe;
        for (int i = 1; i < 8; i++) chain_b[i] <= chain_b[i-1];
    end

    // corrupt only nonzero words so the idle zeros stay clean
    function automatic logic [W-1:0] corrupt(input logic [W-1:0] w);
        return (w == '0) ? w : (w ^ 20'h1);
    endfunction

    always_comb begin
        case (mode_a)
            0:       ifa.echo = ifa.probe;
            1:       ifa.echo = chain_a[tap_a-1];
            2:       ifa.echo = corrupt(chain_a[tap_a-1]);
            default: ifa.echo = '0;
        endcase
        case (mode_b)
            0:       ifb.echo = ifb.probe;
            1:       ifb.echo = chain_b[tap_b-1];
            2:       ifb.echo = corrupt(chain_b[tap_b-1]);
            default: ifb.echo = '0;
        endcase
    end

    task automatic measure(input bit sel, input int budget,
                           output int busy_cyc, output int n_done,
                           output int n_to, output int n_err,
                           output int n_multi, output bit expired);
        busy_cyc = 0; n_done = 0; n_to = 0; n_err = 0;
        n_multi = 0; expired = 1'b1;
        if (sel) ifb.start = 1'b1;
        else     ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        for (int i = 0; i < budget; i++) begin
            logic b, d, t, e;
            b = sel ? ifb.busy    : ifa.busy;
            d = sel ? ifb.done    : ifa.done;
            t = sel ? ifb.timeout : ifa.timeout;
            e = sel ? ifb.err     : ifa.err;
            if (!b) begin
                expired = 1'b0;
                break;
            end
            busy_cyc++;
            n_done += int'(d);
            n_to   += int'(t);
            n_err  += int'(e);
            if (int'(d) + int'(t) + int'(e) > 1) n_multi++;
            @(negedge clk);
        end
    endtask

    task automatic check_run(input string name, input int busy_cyc,
                             input int n_done, input int n_to,
                             input int n_err, input int n_multi,
                             input bit expired, input int exp_busy,
                             input int exp_done, input int exp_to,
                             input int exp_err);
        checks++;
        if (expired !== 1'b0) begin
            fails++;
            $display("FAIL %s_end: busy never fell within budget", name);
        end
        checks++;
        if (busy_cyc !== exp_busy) begin
            fails++;
            $display("FAIL %s_busy: got %0d expected %0d", name, busy_cyc, exp_busy);
        end
        checks++;
        if (n_done !== exp_done || n_to !== exp_to || n_err !== exp_err) begin
            fails++;
            $display("FAIL %s_pulses: done/to/err got %0d/%0d/%0d expected %0d/%0d/%0d",
                     name, n_done, n_to, n_err, exp_done, exp_to, exp_err);
        end
        checks++;
        if (n_multi !== 0) begin
            fails++;
            $display("FAIL %s_onehot: %0d cycles with several pulses", name, n_multi);
        end
    endtask

    int bc, nd, nt, ne, nm;
    bit ex;

    task automatic test_reset();
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        rst = 1'b1;
        repeat (12) @(negedge clk);
        checks++;
        if ({ifa.busy, ifa.done, ifa.timeout, ifa.err} !== 4'b0 ||
            ifa.probe !== '0 || ifa.latency !== '0) begin
            fails++;
            $display("FAIL reset_a: busy=%b done=%b to=%b err=%b probe=%h lat=%0d expected all 0",
                     ifa.busy, ifa.done, ifa.timeout, ifa.err, ifa.probe, ifa.latency);
        end
        checks++;
        if ({ifb.busy, ifb.done, ifb.timeout, ifb.err} !== 4'b0 ||
            ifb.probe !== '0 || ifb.latency !== '0) begin
            fails++;
            $display("FAIL reset_b: busy=%b probe=%h lat=%0d expected all 0",
                     ifb.busy, ifb.probe, ifb.latency);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_loopback();
        mode_a = 0;
        measure(1'b0, 5000, bc, nd, nt, ne, nm, ex);
        check_run("loopback", bc, nd, nt, ne, nm, ex, 4098, 1, 0, 0);
        checks++;
        if (ifa.latency !== 16'd0) begin
            fails++;
            $display("FAIL loopback_lat: got %0d expected 0", ifa.latency);
        end
    endtask

    task automatic test_chain2000();
        mode_a = 1;
        tap_a  = 2000;
        for (int r = 0; r < 2; r++) begin
            measure(1'b0, 7000, bc, nd, nt, ne, nm, ex);
            check_run("chain2000", bc, nd, nt, ne, nm, ex, 6098, 1, 0, 0);
            checks++;
            if (ifa.latency !== 16'd2000) begin
                fails++;
                $display("FAIL chain2000_lat run %0d: got %0d expected 2000", r, ifa.latency);
            end
        end
    endtask

    task automatic test_error();
        mode_a = 2;
        tap_a  = 5;
        measure(1'b0, 5000, bc, nd, nt, ne, nm, ex);
        check_run("error", bc, nd, nt, ne, nm, ex, 4103, 0, 0, 1);
        checks++;
        if (ifa.latency !== 16'd2000) begin
            fails++;
            $display("FAIL error_lat: got %0d expected 2000", ifa.latency);
        end
    endtask

    task automatic test_timeout();
        mode_b = 1;
        tap_b  = 3;
        measure(1'b1, 100, bc, nd, nt, ne, nm, ex);
        check_run("b_chain3", bc, nd, nt, ne, nm, ex, 21, 1, 0, 0);
        mode_b = 3;
        measure(1'b1, 100, bc, nd, nt, ne, nm, ex);
        check_run("timeout", bc, nd, nt, ne, nm, ex, 33, 0, 1, 0);
        checks++;
        if (ifb.latency !== 16'd3) begin
            fails++;
            $display("FAIL timeout_lat: got %0d expected 3", ifb.latency);
        end
    endtask

    task automatic test_reset_mid();
        int stray;
        mode_a = 1;
        tap_a  = 2000;
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        repeat (4096 + 500) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({ifa.busy, ifa.done, ifa.timeout, ifa.err} !== 4'b0 ||
            ifa.probe !== '0 || ifa.latency !== '0) begin
            fails++;
            $display("FAIL reset_mid: busy=%b done=%b to=%b err=%b probe=%h lat=%0d expected all 0",
                     ifa.busy, ifa.done, ifa.timeout, ifa.err, ifa.probe, ifa.latency);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        stray = 0;
        repeat (2500) begin
            @(negedge clk);
            if (ifa.busy || ifa.done || ifa.timeout || ifa.err) stray++;
        end
        checks++;
        if (stray !== 0) begin
            fails++;
            $display("FAIL reset_mid_quiet: %0d active cycles expected 0", stray);
        end
        measure(1'b0, 7000, bc, nd, nt, ne, nm, ex);
        check_run("after_reset", bc, nd, nt, ne, nm, ex, 6098, 1, 0, 0);
        checks++;
        if (ifa.latency !== 16'd2000) begin
            fails++;
            $display("FAIL after_reset_lat: got %0d expected 2000", ifa.latency);
        end
    endtask

    task automatic test_back_to_back();
        int dones, lat1, lat2, gap;
        bit expired;
        dones = 0; lat1 = -1; lat2 = -1; gap = 0; expired = 1'b1;
        mode_a = 1;
        tap_a  = 3;
        ifa.start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2 * 4101 + 20; i++) begin
            if (ifa.done) begin
                dones++;
                if (dones == 1) lat1 = int'(ifa.latency);
                else            lat2 = int'(ifa.latency);
                if (dones == 2) begin
                    expired = 1'b0;
                    break;
                end
            end
            if (dones == 1 && !ifa.busy) gap++;
            @(negedge clk);
        end
        ifa.start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (expired !== 1'b0 || dones !== 2) begin
            fails++;
            $display("FAIL b2b_count: got %0d done pulses expected 2", dones);
        end
        checks++;
        if (lat1 !== 3 || lat2 !== 3) begin
            fails++;
            $display("FAIL b2b_lat: got %0d,%0d expected 3,3", lat1, lat2);
        end
        checks++;
        if (gap !== 1) begin
            fails++;
            $display("FAIL b2b_gap: got %0d idle cycles expected 1", gap);
        end
        checks++;
        if (ifa.busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_idle: busy=%b expected 0", ifa.busy);
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_chain2000();
        test_error();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
